// File: rtl/cmt_rob.sv
// cmt_rob: reorder buffer and in-order commit engine.
//
// Renamed instructions are allocated at the tail (up to IW per cycle).
// Writeback marks entries done. Completed entries retire from the head
// in program order (up to CW per cycle). Each retired lane drives the
// logical/physical mapping and the freed physical register back to rename.
//
// Optional feature macro: NCPU_CMT_EXC_EN
//   defined   -> exception bits, wb_exc/flush/flush_pc ports and the rollback path
//   undefined -> no exception tracking; done entries always retire in order
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rob_push        per-lane allocate request (lanes packed from lane 0)
//   rob_lrd/prd/prd_we/pfree/pc  per-lane entry payload
//   rob_ready       all ones when at least IW entries are free
//   rob_id          entry index assigned to each allocation lane
//   wb_valid/wb_rob_id (/wb_exc)  completion reports
//   flush/flush_pc  one-cycle rollback pulse and faulting PC (exception build)
//   commit_valid/lrd/prd/prd_we/pfree  registered retirement lanes

`ifndef NCPU_LRF_AW
`define NCPU_LRF_AW 5
`endif
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif
`ifndef PC_W
`define PC_W 32
`endif

module cmt_rob #(
    parameter int CONFIG_P_ISSUE_WIDTH  = 1,
    parameter int CONFIG_P_COMMIT_WIDTH = 1,
    parameter int CONFIG_P_ROB_DEPTH    = 4,
    parameter int WRITEBACK_WIDTH       = 2,
    localparam int IW  = 1 << CONFIG_P_ISSUE_WIDTH,
    localparam int CW  = 1 << CONFIG_P_COMMIT_WIDTH,
    localparam int P   = CONFIG_P_ROB_DEPTH,
    localparam int WB  = WRITEBACK_WIDTH,
    localparam int LAW = `NCPU_LRF_AW,
    localparam int PAW = `NCPU_PRF_AW,
    localparam int PCW = `PC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IW-1:0]      rob_push,
    input  logic [IW*LAW-1:0]  rob_lrd,
    input  logic [IW*PAW-1:0]  rob_prd,
    input  logic [IW-1:0]      rob_prd_we,
    input  logic [IW*PAW-1:0]  rob_pfree,
    input  logic [IW*PCW-1:0]  rob_pc,
    output logic [IW-1:0]      rob_ready,
    output logic [IW*P-1:0]    rob_id,
    input  logic [WB-1:0]      wb_valid,
    input  logic [WB*P-1:0]    wb_rob_id,
`ifdef NCPU_CMT_EXC_EN
    input  logic [WB-1:0]      wb_exc,
    output logic               flush,
    output logic [PCW-1:0]     flush_pc,
`endif
    output logic [CW-1:0]      commit_valid,
    output logic [CW*LAW-1:0]  commit_lrd,
    output logic [CW*PAW-1:0]  commit_prd,
    output logic [CW-1:0]      commit_prd_we,
    output logic [CW*PAW-1:0]  commit_pfree
);

    localparam int D = 1 << P;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [P:0] ptr_t;

    ptr_t             head_q;
    ptr_t             tail_q;
    logic [D-1:0]     valid_q;
    logic [D-1:0]     done_q;
    logic [D-1:0]     prd_we_q;
    logic [LAW-1:0]   lrd_q   [D];
    logic [PAW-1:0]   prd_q   [D];
    logic [PAW-1:0]   pfree_q [D];

`ifdef NCPU_CMT_EXC_EN
    logic [D-1:0]     exc_q;
    logic [PCW-1:0]   pc_q [D];
    logic             exc_hit;
    logic [PCW-1:0]   exc_pc;
`else
    logic             unused_pc;
    assign unused_pc = ^rob_pc;
`endif

    ptr_t             count;
    ptr_t             free_cnt;
    ptr_t             push_cnt;
    ptr_t             ret_cnt;
    logic             ready;
    logic             block_in;
    logic             push_fire;
    logic [IW-1:0]    push_lane;
    logic [CW-1:0]    retire;
    logic [P-1:0]     alloc_idx  [IW];
    logic [P-1:0]     commit_idx [CW];

    // Readiness is based on the occupancy before this cycle's retirement,
    // so slots freed by a commit only become allocatable one cycle later.
    assign count     = tail_q - head_q;
    assign free_cnt  = ptr_t'(D) - count;
    assign ready     = (free_cnt >= ptr_t'(IW));
    assign rob_ready = {IW{ready}};

    // During the flush pulse the table has just been emptied; any new
    // allocation or completion belongs to the squashed path.
`ifdef NCPU_CMT_EXC_EN
    assign block_in = flush;
`else
    assign block_in = 1'b0;
`endif

    assign push_fire = ready & ~block_in;
    assign push_lane = rob_push & {IW{push_fire}};

    always_comb begin
        for (int i = 0; i < IW; i++) begin
            alloc_idx[i] = tail_q[P-1:0] + P'(i);
        end
        for (int k = 0; k < CW; k++) begin
            commit_idx[k] = head_q[P-1:0] + P'(k);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < IW; gi++) begin : g_rob_id
            assign rob_id[gi*P +: P] = alloc_idx[gi];
        end
    endgenerate

    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < IW; i++) begin
            if (push_lane[i]) begin
                push_cnt = push_cnt + ptr_t'(1);
            end
        end
    end

    // Retire lanes form a contiguous prefix from the head. The first entry
    // that is not ready (or that faulted) stops every younger lane.
    always_comb begin
        logic chain;
        chain  = 1'b1;
        retire = '0;
`ifdef NCPU_CMT_EXC_EN
        exc_hit = 1'b0;
        exc_pc  = '0;
`endif
        for (int k = 0; k < CW; k++) begin
            if (chain && valid_q[commit_idx[k]] && done_q[commit_idx[k]]) begin
`ifdef NCPU_CMT_EXC_EN
                if (exc_q[commit_idx[k]]) begin
                    exc_hit = 1'b1;
                    exc_pc  = pc_q[commit_idx[k]];
                    chain   = 1'b0;
                end else
`endif
                retire[k] = 1'b1;
            end else begin
                chain = 1'b0;
            end
        end
    end

    always_comb begin
        ret_cnt = '0;
        for (int k = 0; k < CW; k++) begin
            if (retire[k]) begin
                ret_cnt = ret_cnt + ptr_t'(1);
            end
        end
    end

    // Entry table, pointers and registered commit lanes. Writeback is
    // applied before the retire clear so a late duplicate report cannot
    // resurrect a retired slot; allocation never overlaps a live slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            valid_q       <= '0;
            done_q        <= '0;
            prd_we_q      <= '0;
            commit_valid  <= '0;
            commit_lrd    <= '0;
            commit_prd    <= '0;
            commit_prd_we <= '0;
            commit_pfree  <= '0;
`ifdef NCPU_CMT_EXC_EN
            exc_q         <= '0;
            flush         <= 1'b0;
            flush_pc      <= '0;
`endif
        end else begin
            commit_valid <= retire;
            for (int k = 0; k < CW; k++) begin
                commit_lrd[k*LAW +: LAW]   <= retire[k] ? lrd_q[commit_idx[k]]   : '0;
                commit_prd[k*PAW +: PAW]   <= retire[k] ? prd_q[commit_idx[k]]   : '0;
                commit_pfree[k*PAW +: PAW] <= retire[k] ? pfree_q[commit_idx[k]] : '0;
                commit_prd_we[k]           <= retire[k] & prd_we_q[commit_idx[k]];
            end

`ifdef NCPU_CMT_EXC_EN
            flush    <= exc_hit;
            flush_pc <= exc_hit ? exc_pc : '0;
            if (exc_hit) begin
                valid_q <= '0;
                done_q  <= '0;
                exc_q   <= '0;
                head_q  <= '0;
                tail_q  <= '0;
            end else
`endif
            begin
                for (int j = 0; j < WB; j++) begin
                    if (wb_valid[j] && !block_in && valid_q[wb_rob_id[j*P +: P]]) begin
                        done_q[wb_rob_id[j*P +: P]] <= 1'b1;
`ifdef NCPU_CMT_EXC_EN
                        if (wb_exc[j]) begin
                            exc_q[wb_rob_id[j*P +: P]] <= 1'b1;
                        end
`endif
                    end
                end

                for (int k = 0; k < CW; k++) begin
                    if (retire[k]) begin
                        valid_q[commit_idx[k]] <= 1'b0;
                        done_q[commit_idx[k]]  <= 1'b0;
                    end
                end

                for (int i = 0; i < IW; i++) begin
                    if (push_lane[i]) begin
                        valid_q[alloc_idx[i]]  <= 1'b1;
                        done_q[alloc_idx[i]]   <= 1'b0;
                        prd_we_q[alloc_idx[i]] <= rob_prd_we[i];
                        lrd_q[alloc_idx[i]]    <= rob_lrd[i*LAW +: LAW];
                        prd_q[alloc_idx[i]]    <= rob_prd[i*PAW +: PAW];
                        pfree_q[alloc_idx[i]]  <= rob_pfree[i*PAW +: PAW];
`ifdef NCPU_CMT_EXC_EN
                        exc_q[alloc_idx[i]]    <= 1'b0;
                        pc_q[alloc_idx[i]]     <= rob_pc[i*PCW +: PCW];
`endif
                    end
                end

                head_q <= head_q + ret_cnt;
                tail_q <= tail_q + push_cnt;
            end
        end
    end

    // Allocating into a full buffer is a rename-stage protocol error.
    assert property (@(posedge clk) disable iff (rst)
                     (block_in || !(|rob_push) || ready));

endmodule

// File: tb/tb_cmt_rob.sv
// tb_cmt_rob: scoreboard bench for cmt_rob. Expected retirements are queued
// when instructions are issued; a negedge monitor pops and compares every
// lane the DUT reports as committed. Directed checks cover reset values,
// readiness, id assignment, latency and (when enabled) the flush pulse.

`ifndef NCPU_LRF_AW
`define NCPU_LRF_AW 5
`endif
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif
`ifndef PC_W
`define PC_W 32
`endif

module tb_cmt_rob;

    localparam int P   = 4;
    localparam int IW  = 2;
    localparam int CW  = 2;
    localparam int WB  = 2;
    localparam int LAW = `NCPU_LRF_AW;
    localparam int PAW = `NCPU_PRF_AW;
    localparam int PCW = `PC_W;

    typedef struct packed {
        logic [LAW-1:0] lrd;
        logic [PAW-1:0] prd;
        logic           we;
        logic [PAW-1:0] pfree;
    } exp_t;

    logic               clk;
    logic               rst;
    logic [IW-1:0]      rob_push;
    logic [IW*LAW-1:0]  rob_lrd;
    logic [IW*PAW-1:0]  rob_prd;
    logic [IW-1:0]      rob_prd_we;
    logic [IW*PAW-1:0]  rob_pfree;
    logic [IW*PCW-1:0]  rob_pc;
    logic [IW-1:0]      rob_ready;
    logic [IW*P-1:0]    rob_id;
    logic [WB-1:0]      wb_valid;
    logic [WB*P-1:0]    wb_rob_id;
`ifdef NCPU_CMT_EXC_EN
    logic [WB-1:0]      wb_exc;
    logic               flush;
    logic [PCW-1:0]     flush_pc;
`endif
    logic [CW-1:0]      commit_valid;
    logic [CW*LAW-1:0]  commit_lrd;
    logic [CW*PAW-1:0]  commit_prd;
    logic [CW-1:0]      commit_prd_we;
    logic [CW*PAW-1:0]  commit_pfree;

    int   checks;
    int   failures;
    exp_t sb_q[$];
    exp_t mon_act;
    exp_t mon_exp;

    cmt_rob dut (
        .clk           (clk),
        .rst           (rst),
        .rob_push      (rob_push),
        .rob_lrd       (rob_lrd),
        .rob_prd       (rob_prd),
        .rob_prd_we    (rob_prd_we),
        .rob_pfree     (rob_pfree),
        .rob_pc        (rob_pc),
        .rob_ready     (rob_ready),
        .rob_id        (rob_id),
        .wb_valid      (wb_valid),
        .wb_rob_id     (wb_rob_id),
`ifdef NCPU_CMT_EXC_EN
        .wb_exc        (wb_exc),
        .flush         (flush),
        .flush_pc      (flush_pc),
`endif
        .commit_valid  (commit_valid),
        .commit_lrd    (commit_lrd),
        .commit_prd    (commit_prd),
        .commit_prd_we (commit_prd_we),
        .commit_pfree  (commit_pfree)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: every committed lane must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (commit_valid[1] === 1'b1) begin
            checks++;
            if (commit_valid[0] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL commit_lane_packing: got commit_valid=%b expected lane0 set", commit_valid);
            end
        end
        for (int k = 0; k < CW; k++) begin
            if (commit_valid[k] === 1'b1) begin
                mon_act.lrd   = commit_lrd[k*LAW +: LAW];
                mon_act.prd   = commit_prd[k*PAW +: PAW];
                mon_act.we    = commit_prd_we[k];
                mon_act.pfree = commit_pfree[k*PAW +: PAW];
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_commit lane%0d: got lrd=%0d prd=%0d we=%0d pfree=%0d expected no commit",
                             k, mon_act.lrd, mon_act.prd, mon_act.we, mon_act.pfree);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        failures++;
                        $display("[TB] FAIL commit_lane%0d: got lrd=%0d prd=%0d we=%0d pfree=%0d expected lrd=%0d prd=%0d we=%0d pfree=%0d",
                                 k, mon_act.lrd, mon_act.prd, mon_act.we, mon_act.pfree,
                                 mon_exp.lrd, mon_exp.prd, mon_exp.we, mon_exp.pfree);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        rob_push   = '0;
        rob_lrd    = '0;
        rob_prd    = '0;
        rob_prd_we = '0;
        rob_pfree  = '0;
        rob_pc     = '0;
        wb_valid   = '0;
        wb_rob_id  = '0;
`ifdef NCPU_CMT_EXC_EN
        wb_exc     = '0;
`endif
    endtask

    // Drives whatever was staged through one clock edge, then idles the inputs.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clearInputs();
    endtask

    task automatic setPush(input int lane, input int lrd, input int prd, input bit we,
                           input int pfree, input int pc, input bit expect_commit);
        exp_t e;
        rob_push[lane]               = 1'b1;
        rob_lrd[lane*LAW +: LAW]     = LAW'(lrd);
        rob_prd[lane*PAW +: PAW]     = PAW'(prd);
        rob_prd_we[lane]             = we;
        rob_pfree[lane*PAW +: PAW]   = PAW'(pfree);
        rob_pc[lane*PCW +: PCW]      = PCW'(pc);
        if (expect_commit) begin
            e.lrd   = LAW'(lrd);
            e.prd   = PAW'(prd);
            e.we    = we;
            e.pfree = PAW'(pfree);
            sb_q.push_back(e);
        end
    endtask

    task automatic setWb(input int port, input int id);
        wb_valid[port]         = 1'b1;
        wb_rob_id[port*P +: P] = P'(id);
    endtask

`ifdef NCPU_CMT_EXC_EN
    task automatic setWbExc(input int port, input int id);
        setWb(port, id);
        wb_exc[port] = 1'b1;
    endtask
`endif

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rob_ready"}, 64'(rob_ready), 64'h3);
        checkOutput({tag, "_rob_id"}, 64'(rob_id), 64'h10);
        checkOutput({tag, "_commit_valid"}, 64'(commit_valid), 64'h0);
        checkOutput({tag, "_commit_prd_we"}, 64'(commit_prd_we), 64'h0);
        checkOutput({tag, "_commit_lrd"}, 64'(commit_lrd), 64'h0);
        checkOutput({tag, "_commit_prd"}, 64'(commit_prd), 64'h0);
        checkOutput({tag, "_commit_pfree"}, 64'(commit_pfree), 64'h0);
`ifdef NCPU_CMT_EXC_EN
        checkOutput({tag, "_flush"}, 64'(flush), 64'h0);
        checkOutput({tag, "_flush_pc"}, 64'(flush_pc), 64'h0);
`endif
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(name, 64'(sb_q.size()), 64'h0);
        sb_q.delete();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clearInputs();
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        checkResetOutputs("reset");

        // Two-lane push, both complete together, retire together.
        checkOutput("t1_rob_id", 64'(rob_id), 64'h10);
        setPush(0, 3, 40, 1'b1, 3, 'h100, 1'b1);
        setPush(1, 5, 41, 1'b1, 5, 'h104, 1'b1);
        applyStimulus();
        setWb(0, 0);
        setWb(1, 1);
        applyStimulus();
        checkOutput("t1_no_commit_yet", 64'(commit_valid), 64'h0);
        applyStimulus();
        checkOutput("t1_commit_valid", 64'(commit_valid), 64'h3);
        checkOutput("t1_commit_prd", 64'(commit_prd), {52'h0, 6'd41, 6'd40});
        checkOutput("t1_commit_pfree", 64'(commit_pfree), {52'h0, 6'd5, 6'd3});
        applyStimulus();
        checkOutput("t1_commit_idle", 64'(commit_valid), 64'h0);

        // Younger entry completes first; nothing retires until the older one is done.
        checkOutput("t2_rob_id", 64'(rob_id), 64'h32);
        setPush(0, 7, 50, 1'b0, 10, 'h200, 1'b1);
        setPush(1, 8, 51, 1'b1, 11, 'h204, 1'b1);
        applyStimulus();
        setWb(0, 3);
        applyStimulus();
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t2_hold", 64'(commit_valid), 64'h0);
        end
        setWb(0, 2);
        applyStimulus();
        checkOutput("t2_select_cycle", 64'(commit_valid), 64'h0);
        applyStimulus();
        checkOutput("t2_commit_valid", 64'(commit_valid), 64'h3);
        checkOutput("t2_commit_prd_we", 64'(commit_prd_we), 64'h2);
        waitDrain("t2_drain", 20);

        // Reports to empty slots are ignored; reset mid-stream cancels pending commits.
        setWb(0, 9);
        setWb(1, 12);
        applyStimulus();
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t5_invalid_wb", 64'(commit_valid), 64'h0);
        end
        checkOutput("t5_rob_id", 64'(rob_id), 64'h54);
        setPush(0, 1, 20, 1'b1, 21, 'h300, 1'b0);
        setPush(1, 2, 22, 1'b1, 23, 'h304, 1'b0);
        applyStimulus();
        setWb(0, 4);
        setWb(1, 5);
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkResetOutputs("t5_rst");
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
        end
        checkOutput("t5_after_rst", 64'(commit_valid), 64'h0);

        // Fill all 16 entries, free two, wrap the tail, then drain in order.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                checkOutput("t3_ready_before_last", 64'(rob_ready), 64'h3);
            end
            setPush(0, 2*i,   2*i + 16, ((2*i) % 3) == 0,     2*i + 32, 'h1000 + 8*i, 1'b1);
            setPush(1, 2*i+1, 2*i + 17, ((2*i + 1) % 3) == 0, 2*i + 33, 'h1004 + 8*i, 1'b1);
            applyStimulus();
        end
        checkOutput("t3_full", 64'(rob_ready), 64'h0);
        setWb(0, 0);
        setWb(1, 1);
        applyStimulus();
        checkOutput("t3_still_full", 64'(rob_ready), 64'h0);
        applyStimulus();
        checkOutput("t3_freed", 64'(rob_ready), 64'h3);
        checkOutput("t3_wrap_id", 64'(rob_id), 64'h10);
        setPush(0, 16, 32, 1'b1, 48, 'h2000, 1'b1);
        setPush(1, 17, 33, 1'b0, 49, 'h2004, 1'b1);
        applyStimulus();
        checkOutput("t3_full_again", 64'(rob_ready), 64'h0);
        for (int j = 2; j < 16; j += 2) begin
            setWb(0, j);
            setWb(1, j + 1);
            applyStimulus();
        end
        setWb(0, 0);
        setWb(1, 1);
        applyStimulus();
        waitDrain("t3_drain", 40);

`ifdef NCPU_CMT_EXC_EN
        // Faulting entry: older lane retires, then flush pulse with its PC.
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        setPush(0, 1, 10, 1'b1, 11, 'h400, 1'b1);
        setPush(1, 2, 12, 1'b1, 13, 'h404, 1'b1);
        applyStimulus();
        setPush(0, 3, 14, 1'b1, 15, 'h408, 1'b1);
        setPush(1, 4, 16, 1'b1, 17, 'h40c, 1'b1);
        applyStimulus();
        setWb(0, 0);
        setWb(1, 1);
        applyStimulus();
        setWb(0, 2);
        setWb(1, 3);
        applyStimulus();
        applyStimulus();
        checkOutput("t4_rob_id", 64'(rob_id), 64'h54);
        setPush(0, 5, 18, 1'b1, 19, 'h410, 1'b1);
        setPush(1, 6, 20, 1'b1, 21, 'h5a0, 1'b0);
        applyStimulus();
        setWb(0, 4);
        setWbExc(1, 5);
        applyStimulus();
        checkOutput("t4_no_flush_yet", 64'(flush), 64'h0);
        applyStimulus();
        checkOutput("t4_commit_valid", 64'(commit_valid), 64'h1);
        checkOutput("t4_flush", 64'(flush), 64'h1);
        checkOutput("t4_flush_pc", 64'(flush_pc), 64'h5a0);
        checkOutput("t4_ready", 64'(rob_ready), 64'h3);
        checkOutput("t4_rob_id_reset", 64'(rob_id), 64'h10);
        setPush(0, 9, 30, 1'b1, 31, 'h600, 1'b0);
        setWb(0, 0);
        applyStimulus();
        checkOutput("t4_flush_pulse_end", 64'(flush), 64'h0);
        checkOutput("t4_push_ignored", 64'(rob_id), 64'h10);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
        end
        checkOutput("t4_no_late_commit", 64'(commit_valid), 64'h0);
        waitDrain("t4_drain", 10);
`endif

        applyStimulus();
        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
